// File: rtl/dp_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : dp_stream_reader_if
// Purpose  : Valid/ready point stream (data, index, last) from the ROM reader.
// Revision : 1.0
// ============================================================================
interface dp_stream_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_index,
    input  m_last,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/dp_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : dp_stream_reader
// Purpose  : Scans the dataPoints ROM 0..count-1 and re-emits each point as a
//            valid/ready stream through a credit-limited prefetch FIFO.
// Config   : DP_READER_CHECKSUM_EN adds a running checksum output.
// Revision : 1.0
// ============================================================================
module dp_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                start,
  input  logic [ADDR_W:0]     count,
  output logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   douta,
  dp_stream_reader_if.master  m,
`ifdef DP_READER_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
  output logic                busy,
`else
  output logic                busy,
`endif
  output logic                done
);

  localparam int c_ptr_w = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int c_cnt_w = $clog2(FIFO_D + RD_LAT + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_max = c_ptr_w'(FIFO_D - 1);
  localparam logic [c_cnt_w-1:0] c_fifo_d  = c_cnt_w'(FIFO_D);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_last_addr;

  logic [RD_LAT-1:0]   r_tag_vld;
  logic [RD_LAT-1:0]   r_tag_last;
  logic [ADDR_W-1:0]   r_tag_idx [RD_LAT];

  logic [DATA_W-1:0]   r_mem_data [FIFO_D];
  logic [ADDR_W-1:0]   r_mem_idx  [FIFO_D];
  logic [FIFO_D-1:0]   r_mem_last;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_occ;
  logic [c_cnt_w-1:0]  w_inflight;

  logic                w_accept;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_drained;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + c_cnt_w'(r_tag_vld[i]);
    end
  end

  // Credits count both buffered and in-flight reads so a push never overflows.
  assign w_accept  = (r_state == IDLE) & start;
  assign w_issue   = (r_state == FETCH) & ((r_occ + w_inflight) < c_fifo_d);
  assign w_push    = r_tag_vld[RD_LAT-1];
  assign w_pop     = m.m_valid & m.m_ready;
  assign w_drained = w_pop & m.m_last & (r_occ == c_cnt_w'(1)) & (w_inflight == '0);

  assign m.m_valid = (r_occ != '0);
  assign m.m_data  = r_mem_data[r_rd_ptr];
  assign m.m_index = r_mem_idx[r_rd_ptr];
  assign m.m_last  = r_mem_last[r_rd_ptr];

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_state_nxt = (count != '0) ? FETCH : DONE;
      FETCH: if (w_issue && (addra == r_last_addr)) w_state_nxt = DRAIN;
      DRAIN: if (w_drained) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (r_state == FETCH) | (r_state == DRAIN);
      done <= (r_state == DONE);
    end
  end

  // addra holds the next address to fetch; the ROM samples it on the issue edge.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      addra       <= '0;
      r_last_addr <= '0;
    end else begin
      if (w_accept) begin
        r_last_addr <= ADDR_W'(count - (ADDR_W + 1)'(1));
      end
      if (w_accept && (count != '0)) begin
        addra <= '0;
      end else if (w_issue) begin
        addra <= addra + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_tag_vld  <= '0;
      r_tag_last <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_idx[i] <= '0;
      end
    end else begin
      r_tag_vld[0]  <= w_issue;
      r_tag_last[0] <= w_issue & (addra == r_last_addr);
      r_tag_idx[0]  <= addra;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
        r_tag_idx[i]  <= r_tag_idx[i-1];
      end
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_mem_last <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= douta;
        r_mem_idx[r_wr_ptr]  <= r_tag_idx[RD_LAT-1];
        r_mem_last[r_wr_ptr] <= r_tag_last[RD_LAT-1];
        r_wr_ptr <= (r_wr_ptr == c_ptr_max) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_max) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + c_cnt_w'(1);
        2'b01:   r_occ <= r_occ - c_cnt_w'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef DP_READER_CHECKSUM_EN
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      checksum <= '0;
    end else if (w_accept) begin
      checksum <= '0;
    end else if (w_pop) begin
      checksum <= checksum + m.m_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_stream_reader
// Purpose  : Self-checking bench for dp_stream_reader with a behavioural ROM.
// Revision : 1.0
// ============================================================================
module tb_dp_stream_reader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clka  = 1'b0;
  logic              rsta  = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   count = '0;
  logic              ready = 1'b1;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] douta;
  logic              busy;
  logic              done;
`ifdef DP_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rom_mode = 0;

  dp_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) strm ();
  assign strm.m_ready = ready;

  dp_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .FIFO_D(4)) dut (
    .clka     (clka),
    .rsta     (rsta),
    .start    (start),
    .count    (count),
    .addra    (addra),
    .douta    (douta),
    .m        (strm),
`ifdef DP_READER_CHECKSUM_EN
    .checksum (checksum),
`endif
    .busy     (busy),
    .done     (done)
  );

  always #5 clka = ~clka;

  function automatic logic [31:0] rom_val(input logic [7:0] a);
    if (rom_mode == 1) return 32'h8000_0000;
    return 32'(a) * 32'd3;
  endfunction

  always @(posedge clka) douta <= rom_val(addra);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one scan, scoreboarding every accepted beat and the done pulse.
  task automatic run_scan(input int cnt, input bit toggle, input string tag);
    int beats = 0;
    int cyc = 0;
    int first = -1;
    int lastc = -1;
    bit seen_done = 0;
    bit stalled = 0;
    logic newready;
    logic [40:0] prev;
    @(negedge clka);
    start = 1'b1; count = (ADDR_W+1)'(cnt); ready = 1'b1;
    @(negedge clka);
    start = 1'b0;
    while (!seen_done && cyc < 2000) begin
      if (done) begin
        seen_done = 1;
      end else begin
        newready = toggle ? ~ready : 1'b1;
        if (stalled)
          chk({tag, "_hold"}, {strm.m_valid, strm.m_data, strm.m_index, strm.m_last}, {1'b1, prev});
        if (strm.m_valid && newready) begin
          chk({tag, "_beat"}, {strm.m_data, strm.m_index, strm.m_last},
              {rom_val(8'(beats)), 8'(beats), 1'(beats == cnt - 1)});
          if (first < 0) first = cyc;
          lastc = cyc;
          beats++;
        end
        stalled = strm.m_valid && !newready;
        prev = {strm.m_data, strm.m_index, strm.m_last};
        ready = newready;
        @(negedge clka);
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    chk({tag, "_beat_count"}, 64'(beats), 64'(cnt));
    if (!toggle) chk({tag, "_back2back"}, 64'(lastc - first), 64'(cnt - 1));
`ifdef DP_READER_CHECKSUM_EN
    if (rom_mode == 1) chk({tag, "_checksum"}, 64'(checksum), 64'h8000_0000);
`endif
    @(negedge clka);
    ready = 1'b1;
    chk({tag, "_done_single"}, {62'd0, done, busy}, 64'd0);
  endtask

  typedef struct {
    logic        start;
    logic [8:0]  count;
    logic        valid;
    logic [31:0] data;
    logic [7:0]  index;
    logic        last;
    logic        busy;
    logic        done;
    logic [7:0]  addra;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [ADDR_W-1:0] a0;
    bit found;
    vt[0]  = '{start:1, count:5, valid:0, data:0,  index:0, last:0, busy:0, done:0, addra:0};
    vt[1]  = '{start:0, count:5, valid:0, data:0,  index:0, last:0, busy:0, done:0, addra:0};
    vt[2]  = '{start:0, count:5, valid:0, data:0,  index:0, last:0, busy:1, done:0, addra:1};
    vt[3]  = '{start:0, count:5, valid:1, data:0,  index:0, last:0, busy:1, done:0, addra:2};
    vt[4]  = '{start:0, count:5, valid:1, data:3,  index:1, last:0, busy:1, done:0, addra:3};
    vt[5]  = '{start:0, count:5, valid:1, data:6,  index:2, last:0, busy:1, done:0, addra:4};
    vt[6]  = '{start:0, count:5, valid:1, data:9,  index:3, last:0, busy:1, done:0, addra:5};
    vt[7]  = '{start:0, count:5, valid:1, data:12, index:4, last:1, busy:1, done:0, addra:5};
    vt[8]  = '{start:0, count:5, valid:0, data:0,  index:0, last:0, busy:1, done:0, addra:5};
    vt[9]  = '{start:0, count:5, valid:0, data:0,  index:0, last:0, busy:0, done:1, addra:5};
    vt[10] = '{start:0, count:5, valid:0, data:0,  index:0, last:0, busy:0, done:0, addra:5};

    repeat (3) @(negedge clka);
    chk("reset_state", {strm.m_valid, strm.m_data, strm.m_index, strm.m_last, busy, done, addra}, 64'd0);
    rsta = 1'b0;

    // count=5 cycle by cycle
    for (int i = 0; i < 11; i++) begin
      @(negedge clka);
      chk($sformatf("vec%0d_ctrl", i), {strm.m_valid, busy, done, addra},
          {vt[i].valid, vt[i].busy, vt[i].done, vt[i].addra});
      if (vt[i].valid)
        chk($sformatf("vec%0d_beat", i), {strm.m_data, strm.m_index, strm.m_last},
            {vt[i].data, vt[i].index, vt[i].last});
      start = vt[i].start; count = vt[i].count; ready = 1'b1;
    end

    // count=0: done two cycles after start, nothing else moves
    @(negedge clka);
    a0 = addra;
    start = 1'b1; count = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clka);
      start = 1'b0;
      chk($sformatf("zero_cnt_c%0d", k), {strm.m_valid, done, addra}, {1'b0, 1'(k == 2), a0});
    end

    run_scan(256, 1'b0, "full256");
    chk("full256_addra_wrap", 64'(addra), 64'd0);

    run_scan(8, 1'b1, "toggle8");

    // reset in the middle of a 10-point scan
    @(negedge clka);
    start = 1'b1; count = 9'd10; ready = 1'b1;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clka);
      start = 1'b0;
      if (strm.m_valid && strm.m_index == 8'd3) found = 1;
    end
    chk("midreset_reach_beat3", 64'(found), 64'd1);
    rsta = 1'b1;
    #1;
    chk("midreset_outputs", {strm.m_valid, strm.m_data, strm.m_index, strm.m_last, busy, done, addra}, 64'd0);
    @(negedge clka);
    @(negedge clka);
    rsta = 1'b0;
    chk("midreset_no_done", {62'd0, done, busy}, 64'd0);
    run_scan(2, 1'b0, "after_reset2");

`ifdef DP_READER_CHECKSUM_EN
    rom_mode = 1;
    run_scan(3, 1'b0, "cksum3");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
